apple_placer: RTL and testbench

- Parametrised successor to the single-cycle apple generator.
- Places one apple on a ROWS x COLS playfield per request. Picks a candidate cell from an internal LFSR, or from a forced coordinate, and checks it against the red/green occupancy grids.
- If the candidate is occupied, probes its in-bounds neighbours, then raster-scans one cell per clock until a free cell is found or the grid is proven full.
- Sits between the game-control FSM (issues req) and the LED driver (consumes x, y).

---
 rtl/apple_placer_if.sv | 30 +++
 rtl/apple_placer.sv | 171 +++++++++++++++++
 tb/tb_apple_placer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/apple_placer_if.sv
// Request/result bundle between the game-control FSM (master) and the apple placer (slave).
interface apple_placer_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
);
  localparam int XW = $clog2(ROWS);
  localparam int YW = $clog2(COLS);

  logic                      req;
  logic                      fix_en;
  logic [XW-1:0]             fix_x;
  logic [YW-1:0]             fix_y;
  logic [ROWS-1:0][COLS-1:0] RedPixels;
  logic [ROWS-1:0][COLS-1:0] GrnPixels;
  logic                      busy;
  logic                      valid;
  logic                      full;
  logic [XW-1:0]             x;
  logic [YW-1:0]             y;

  modport master (
    output req, fix_en, fix_x, fix_y, RedPixels, GrnPixels,
    input  busy, valid, full, x, y
  );

  modport slave (
    input  req, fix_en, fix_x, fix_y, RedPixels, GrnPixels,
    output busy, valid, full, x, y
  );
endinterface

// File: rtl/apple_placer.sv
// Apple placer: LFSR or forced candidate, optional neighbour probe, then a one-cell-per-clock raster scan.
// Build option: define APPLE_NEIGHBOR_PROBE_EN to enable the neighbour probe (NBR state).
module apple_placer #(
  parameter int          ROWS    = 16,
  parameter int          COLS    = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          RESET_X = 12,
  parameter int          RESET_Y = 12
) (
  input logic           clk,
  input logic           reset,
  apple_placer_if.slave bus
);
  localparam int XW = $clog2(ROWS);
  localparam int YW = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, PROBE, NBR, SCAN} state_t;

  state_t        state_reg;
  logic [15:0]   lfsr_reg;
  logic [15:0]   lfsr_next;
  logic [XW-1:0] cx_reg, sx_reg, x_reg;
  logic [YW-1:0] cy_reg, sy_reg, y_reg;
  logic          busy_reg, valid_reg, full_reg;

  logic [ROWS-1:0][COLS-1:0] occ_grid;
  logic [XW-1:0]             fx_mod, lx_mod, base_x, nx;
  logic [YW-1:0]             fy_mod, ly_mod, base_y, ny;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_occ
      assign occ_grid[gi] = bus.RedPixels[gi] | bus.GrnPixels[gi];
    end
  endgenerate

  assign lfsr_next = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ 16'hB400) : (lfsr_reg >> 1);

  // Forced coordinates are always below 2*ROWS / 2*COLS, so one conditional subtract reduces them.
  assign fx_mod = (32'(bus.fix_x) >= ROWS) ? XW'(32'(bus.fix_x) - ROWS) : bus.fix_x;
  assign fy_mod = (32'(bus.fix_y) >= COLS) ? YW'(32'(bus.fix_y) - COLS) : bus.fix_y;
  assign lx_mod = XW'(32'(lfsr_reg[7:0]) % ROWS);
  assign ly_mod = YW'(32'(lfsr_reg[15:8]) % COLS);

  // Row-major successor of the current cell, kept as (row, col) so no divider is needed.
  always_comb begin
    base_x = (state_reg == SCAN) ? sx_reg : cx_reg;
    base_y = (state_reg == SCAN) ? sy_reg : cy_reg;
    nx     = base_x;
    ny     = base_y + 1'b1;
    if (32'(base_y) == COLS - 1) begin
      ny = '0;
      nx = (32'(base_x) == ROWS - 1) ? '0 : base_x + 1'b1;
    end
  end

`ifdef APPLE_NEIGHBOR_PROBE_EN
  logic          nbr_hit;
  logic [XW-1:0] nbr_x;
  logic [YW-1:0] nbr_y;

  // Later checks overwrite earlier ones, so they run from lowest to highest priority.
  always_comb begin
    nbr_hit = 1'b0;
    nbr_x   = cx_reg;
    nbr_y   = cy_reg;
    if (32'(cx_reg) < ROWS - 1 && !occ_grid[cx_reg + 1'b1][cy_reg]) begin
      nbr_hit = 1'b1; nbr_x = cx_reg + 1'b1; nbr_y = cy_reg;
    end
    if (cx_reg != '0 && !occ_grid[cx_reg - 1'b1][cy_reg]) begin
      nbr_hit = 1'b1; nbr_x = cx_reg - 1'b1; nbr_y = cy_reg;
    end
    if (cy_reg != '0 && !occ_grid[cx_reg][cy_reg - 1'b1]) begin
      nbr_hit = 1'b1; nbr_x = cx_reg; nbr_y = cy_reg - 1'b1;
    end
    if (32'(cy_reg) < COLS - 1 && !occ_grid[cx_reg][cy_reg + 1'b1]) begin
      nbr_hit = 1'b1; nbr_x = cx_reg; nbr_y = cy_reg + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      lfsr_reg  <= SEED;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      full_reg  <= 1'b0;
      x_reg     <= XW'(RESET_X);
      y_reg     <= YW'(RESET_Y);
      cx_reg    <= '0;
      cy_reg    <= '0;
      sx_reg    <= '0;
      sy_reg    <= '0;
    end else begin
      lfsr_reg  <= lfsr_next;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            cx_reg    <= bus.fix_en ? fx_mod : lx_mod;
            cy_reg    <= bus.fix_en ? fy_mod : ly_mod;
            full_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= PROBE;
          end
        end
        PROBE: begin
          if (!occ_grid[cx_reg][cy_reg]) begin
            x_reg     <= cx_reg;
            y_reg     <= cy_reg;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
`ifdef APPLE_NEIGHBOR_PROBE_EN
            state_reg <= NBR;
`else
            sx_reg    <= nx;
            sy_reg    <= ny;
            state_reg <= SCAN;
`endif
          end
        end
`ifdef APPLE_NEIGHBOR_PROBE_EN
        NBR: begin
          if (nbr_hit) begin
            x_reg     <= nbr_x;
            y_reg     <= nbr_y;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            sx_reg    <= nx;
            sy_reg    <= ny;
            state_reg <= SCAN;
          end
        end
`endif
        SCAN: begin
          // Back at the candidate: every other cell was occupied when visited.
          if (sx_reg == cx_reg && sy_reg == cy_reg) begin
            full_reg  <= 1'b1;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (!occ_grid[sx_reg][sy_reg]) begin
            x_reg     <= sx_reg;
            y_reg     <= sy_reg;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            sx_reg <= nx;
            sy_reg <= ny;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.valid = valid_reg;
  assign bus.full  = full_reg;
  assign bus.x     = x_reg;
  assign bus.y     = y_reg;
endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer on a 16x16 field; latencies follow APPLE_NEIGHBOR_PROBE_EN.
module tb_apple_placer;
`ifdef APPLE_NEIGHBOR_PROBE_EN
  localparam int NB = 1;
`else
  localparam int NB = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat;
  int   pulses;
  logic [15:0] mlfsr;
  logic [31:0] exp_lr, exp_lc;
  logic [31:0] px, py;

  always #5 clk = ~clk;

  apple_placer_if #(.ROWS(16), .COLS(16)) bus ();

  apple_placer #(.ROWS(16), .COLS(16), .SEED(16'hACE1), .RESET_X(12), .RESET_Y(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference LFSR: reset to the seed, Galois mask 16'hB400, one step per clock.
  always @(posedge clk) begin
    if (!reset) mlfsr <= 16'hACE1;
    else        mlfsr <= mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one request for a single edge; returns #1 after the accept edge.
  task automatic issue(input logic fen, input logic [3:0] fx, input logic [3:0] fy);
    @(negedge clk);
    bus.req    = 1'b1;
    bus.fix_en = fen;
    bus.fix_x  = fx;
    bus.fix_y  = fy;
    exp_lr     = 32'(mlfsr[7:0]) % 16;
    exp_lc     = 32'(mlfsr[15:8]) % 16;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  // Cycle count from the accept edge (= cycle 1 right after issue) to the valid pulse.
  task automatic wait_valid(output int n);
    n = 1;
    while (bus.valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    bus.req       = 1'b0;
    bus.fix_en    = 1'b0;
    bus.fix_x     = '0;
    bus.fix_y     = '0;
    bus.RedPixels = '0;
    bus.GrnPixels = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_x", 32'(bus.x), 12);
    check("rst_y", 32'(bus.y), 12);
    @(negedge clk);
    reset = 1'b1;

    // Free forced candidate
    issue(1'b1, 4'd12, 4'd12);
    check("free_busy", 32'(bus.busy), 1);
    wait_valid(lat);
    $display("free: lat=%0d x=%0d y=%0d full=%0d", lat, bus.x, bus.y, bus.full);
    check("free_lat", lat, 2);
    check("free_x", 32'(bus.x), 12);
    check("free_y", 32'(bus.y), 12);
    check("free_full", 32'(bus.full), 0);
    check("free_busy_done", 32'(bus.busy), 0);

    // Occupied candidate with a free neighbour to the left (right is taken)
    bus.RedPixels[12][12] = 1'b1;
    bus.GrnPixels[12][13] = 1'b1;
    issue(1'b1, 4'd12, 4'd12);
    wait_valid(lat);
    $display("nbr: lat=%0d x=%0d y=%0d", lat, bus.x, bus.y);
    check("nbr_lat", lat, NB ? 3 : 4);
    check("nbr_x", 32'(bus.x), 12);
    check("nbr_y", 32'(bus.y), NB ? 11 : 14);

    // Corner candidate: left/up out of bounds, scan finds (0,2) as k=2
    bus.RedPixels = '0;
    bus.GrnPixels = '0;
    bus.RedPixels[0][0] = 1'b1;
    bus.RedPixels[0][1] = 1'b1;
    bus.GrnPixels[1][0] = 1'b1;
    issue(1'b1, 4'd0, 4'd0);
    wait_valid(lat);
    $display("corner: lat=%0d x=%0d y=%0d", lat, bus.x, bus.y);
    check("corner_lat", lat, NB ? 5 : 4);
    check("corner_x", 32'(bus.x), 0);
    check("corner_y", 32'(bus.y), 2);

    // Scan from (15,15) wraps to index 0; only (3,7) = index 55 is free, reached at k=56
    bus.GrnPixels = '0;
    bus.RedPixels = '1;
    bus.RedPixels[3][7] = 1'b0;
    issue(1'b1, 4'd15, 4'd15);
    wait_valid(lat);
    $display("wrap: lat=%0d x=%0d y=%0d", lat, bus.x, bus.y);
    check("wrap_lat", lat, 2 + NB + 56);
    check("wrap_x", 32'(bus.x), 3);
    check("wrap_y", 32'(bus.y), 7);

    // Completely full grid
    bus.RedPixels[3][7] = 1'b1;
    issue(1'b1, 4'd5, 4'd5);
    wait_valid(lat);
    $display("full: lat=%0d x=%0d y=%0d full=%0d", lat, bus.x, bus.y, bus.full);
    check("full_lat", lat, 2 + NB + 256);
    check("full_flag", 32'(bus.full), 1);
    check("full_x_held", 32'(bus.x), 3);
    check("full_y_held", 32'(bus.y), 7);
    @(posedge clk);
    #1;
    check("full_valid_pulse", 32'(bus.valid), 0);
    check("full_hold", 32'(bus.full), 1);

    // Next request clears full
    bus.RedPixels[5][9] = 1'b0;
    issue(1'b1, 4'd5, 4'd9);
    check("clr_full", 32'(bus.full), 0);
    wait_valid(lat);
    $display("refill: lat=%0d x=%0d y=%0d full=%0d", lat, bus.x, bus.y, bus.full);
    check("refill_lat", lat, 2);
    check("refill_x", 32'(bus.x), 5);
    check("refill_y", 32'(bus.y), 9);

    // LFSR candidate on an empty grid
    bus.RedPixels = '0;
    issue(1'b0, 4'd0, 4'd0);
    wait_valid(lat);
    $display("lfsr: lat=%0d x=%0d y=%0d exp=(%0d,%0d)", lat, bus.x, bus.y, exp_lr, exp_lc);
    check("lfsr_lat", lat, 2);
    check("lfsr_x", 32'(bus.x), exp_lr);
    check("lfsr_y", 32'(bus.y), exp_lc);

    // Reset during a long scan aborts with no valid
    bus.RedPixels = '1;
    issue(1'b1, 4'd12, 4'd12);
    repeat (20) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(bus.busy), 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    $display("abort: busy=%0d valid=%0d x=%0d y=%0d", bus.busy, bus.valid, bus.x, bus.y);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_valid", 32'(bus.valid), 0);
    check("abort_x", 32'(bus.x), 12);
    check("abort_y", 32'(bus.y), 12);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) pulses++;
    end
    check("abort_no_valid", pulses, 0);

    // A req while busy is ignored: exactly one valid, for the first request
    bus.RedPixels = '0;
    bus.RedPixels[0][0] = 1'b1;
    bus.RedPixels[0][1] = 1'b1;
    bus.RedPixels[1][0] = 1'b1;
    issue(1'b1, 4'd0, 4'd0);
    issue(1'b1, 4'd7, 4'd7);
    pulses = 0;
    px = '0;
    py = '0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid === 1'b1) begin
        pulses++;
        px = 32'(bus.x);
        py = 32'(bus.y);
      end
      @(posedge clk);
      #1;
    end
    $display("busy_req: pulses=%0d x=%0d y=%0d", pulses, px, py);
    check("busy_req_pulses", pulses, 1);
    check("busy_req_x", px, 0);
    check("busy_req_y", py, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
